flags_branch_unit: RTL and testbench
====================================

Name: flags_branch_unit

Overview:
- Consumer end of the ALU flag interface.
- Latches NZCV whenever the ALU signals a flag-setting operation (ADDS/SUBS/ADDIS/SUBIS).
- Resolves B.cond requests against the held flags and hands a registered taken/not-taken decision plus target to fetch over a valid/ready handshake.
- Sits between EX (ALU flag outputs) and the PC-select logic.

Parameters:
- N, 64, width of branch target address.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flags_valid  in  1  EX stage holds a real (non-bubble) instruction this cycle.
- write_flags  in  1  ALU flag-write strobe; effective only when flags_valid=1.
- zero_flag  in  1  ALU Z.
- negative  in  1  ALU N.
- carry  in  1  ALU C.
- overflow  in  1  ALU V.
- br_valid  in  1  branch request present.
- br_cond  in  4  ARM condition code.
- br_target  in  N  branch target address.
- br_ready  out  1  request accepted this cycle when br_valid&br_ready.
- res_valid  out  1  resolved decision available.
- res_taken  out  1  1 = branch taken.
- res_target  out  N  target, copied from br_target.
- res_ready  in  1  fetch consumes result when res_valid&res_ready.
- flush  in  1  discard held result and any request offered this cycle.
- nzcv  out  4  current flag register {N,Z,C,V}, for debug/trace.

Behaviour:
- Reset (async, reset_n=0): nzcv=4'b0000, res_valid=0, res_taken=0, res_target=0.
- Flag register:
  - Updates on the clock edge where flags_valid&write_flags=1, loading {negative, zero_flag, carry, overflow}.
  - Otherwise holds.
  - flush does not affect nzcv.
- Condition evaluation on flags F (N,Z,C,V):
  - 0 EQ: Z. 1 NE: !Z. 2 HS: C. 3 LO: !C. 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. 10 GE: N==V. 11 LT: N!=V. 12 GT: !Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 1 (always, per ARMv8).
- Output stage: a single register.
  - br_ready = !flush & (!res_valid | res_ready) & bypass_ok (see Optional Feature).
- On accept (br_valid&br_ready): next cycle res_valid=1, res_taken=cond(F), res_target=br_target. Latency is exactly 1 cycle.
- Result held stable (taken, target) while res_valid&!res_ready.
- Consume without a new accept: res_valid->0 next cycle; res_taken and res_target keep their last values.
- Consume and accept in the same cycle: back-to-back, with res_valid staying 1 and new contents loaded. Throughput is 1 branch/cycle.
- flush=1: res_valid->0 next cycle regardless of res_ready; no request is accepted that cycle.
- Flags write and branch accept in the same cycle: F selection governed by the Optional Feature.
- Flags write with no branch: only nzcv changes; the output stage is untouched.
- Reset asserted mid-handshake: result lost, res_valid=0 immediately (async).

Optional Feature:
- Macro FLAGS_BYPASS_EN.
- Defined:
  - bypass_ok=1 always.
  - When flags_valid&write_flags is high in the accept cycle, F = incoming ALU flags (forwarded), giving the same result as if the flags had been written first.
  - Otherwise F = nzcv.
- Undefined:
  - F = nzcv always.
  - bypass_ok = !(flags_valid&write_flags), so a branch offered in a flag-write cycle is stalled one cycle (br_ready=0) and evaluated next cycle against the updated nzcv.

Test Plan:
- Reset then idle -> nzcv=0000, res_valid=0. Then br_cond=14 (AL), br_target=0x400 -> next cycle res_valid=1, res_taken=1, res_target=0x400.
- Flag write Z=1,N=0,C=1,V=0 (SUBS equal operands), then branches 0,1,8,9,10 -> taken 1,0,0,1,1.
- Flag write N=1,V=0, then br_cond=11 (LT) and 12 (GT) -> taken 1 and 0. Flag write with flags_valid=0 -> nzcv unchanged.
- res_ready=0 for 3 cycles with res_valid=1 -> br_ready=0, outputs stable. Then res_ready=1 with a new br_valid -> back-to-back result the next cycle, no bubble.
- Same-cycle write Z=1 (nzcv Z=0 before) plus br_cond=0:
  - FLAGS_BYPASS_EN defined -> accepted, res_taken=1 one cycle later.
  - FLAGS_BYPASS_EN undefined -> br_ready=0 that cycle, accepted next, res_taken=1 two cycles after first offer.
- flush=1 while res_valid=1 and br_valid=1 -> res_valid=0 next cycle, request not accepted. reset_n pulse low mid-hold -> res_valid drops immediately, nzcv=0000.

Source files
------------

// File: rtl/flags_branch_unit.sv
// -----------------------------------------------------------------------------
// flags_branch_unit
//
// Consumer end of the ALU flag interface. Holds the architectural NZCV flags,
// loads them whenever EX retires a flag-setting operation, and resolves B.cond
// requests against them. Each decision (taken / not-taken plus the target) is
// registered and handed to the PC-select logic over a valid/ready handshake.
//
// Build option:
//   FLAGS_BYPASS_EN  defined   -> a branch offered in the same cycle as a flag
//                                 write is accepted and sees the incoming ALU
//                                 flags (forwarded).
//                    undefined -> such a branch is stalled one cycle and is
//                                 evaluated against the updated register.
//
// Ports:
//   clk, reset_n               clock (rising edge), async active-low reset
//   flags_valid, write_flags   flag load strobe (effective when both high)
//   zero_flag, negative,
//   carry, overflow            ALU flag outputs
//   br_valid, br_ready         branch request handshake
//   br_cond, br_target         ARM condition code and branch target
//   res_valid, res_ready       resolved-result handshake towards fetch
//   res_taken, res_target      resolved decision and copied target
//   flush                      drop held result and any request this cycle
//   nzcv                       current flag register {N,Z,C,V}
// -----------------------------------------------------------------------------
module flags_branch_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flags_valid,
    input  logic         write_flags,
    input  logic         zero_flag,
    input  logic         negative,
    input  logic         carry,
    input  logic         overflow,
    input  logic         br_valid,
    input  logic [3:0]   br_cond,
    input  logic [N-1:0] br_target,
    output logic         br_ready,
    output logic         res_valid,
    output logic         res_taken,
    output logic [N-1:0] res_target,
    input  logic         res_ready,
    input  logic         flush,
    output logic [3:0]   nzcv
);

    // Condition evaluation on flags f = {N,Z,C,V}.
    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv;
        logic r;
        fn = f[3];
        fz = f[2];
        fc = f[1];
        fv = f[0];
        case (cc)
            4'd0:    r = fz;
            4'd1:    r = !fz;
            4'd2:    r = fc;
            4'd3:    r = !fc;
            4'd4:    r = fn;
            4'd5:    r = !fn;
            4'd6:    r = fv;
            4'd7:    r = !fv;
            4'd8:    r = fc & !fz;
            4'd9:    r = !fc | fz;
            4'd10:   r = (fn == fv);
            4'd11:   r = (fn != fv);
            4'd12:   r = !fz & (fn == fv);
            4'd13:   r = fz | (fn != fv);
            default: r = 1'b1;          // AL and NV both always execute
        endcase
        return r;
    endfunction

    logic         flag_we;
    logic [3:0]   alu_flags;
    logic [3:0]   eval_flags;
    logic         bypass_ok;
    logic         accept;
    logic [15:0]  cond_vec;

    logic [3:0]   nzcv_reg,       nzcv_next;
    logic         res_valid_reg,  res_valid_next;
    logic         res_taken_reg,  res_taken_next;
    logic [N-1:0] res_target_reg, res_target_next;

    assign flag_we   = flags_valid & write_flags;
    assign alu_flags = {negative, zero_flag, carry, overflow};

`ifdef FLAGS_BYPASS_EN
    // Forward the flags being written this cycle so a dependent branch does
    // not have to wait for them to land in the register.
    assign eval_flags = flag_we ? alu_flags : nzcv_reg;
    assign bypass_ok  = 1'b1;
`else
    // No forwarding path: hold the branch off until the write has landed.
    assign eval_flags = nzcv_reg;
    assign bypass_ok  = !flag_we;
`endif

    // Every condition is evaluated in parallel; br_cond just selects one.
    for (genvar gi = 0; gi < 16; gi++) begin : g_cond
        assign cond_vec[gi] = cond_holds(4'(gi), eval_flags);
    end

    // The single output register can take a new result when it is empty or
    // is being drained in this same cycle.
    assign br_ready = !flush & (!res_valid_reg | res_ready) & bypass_ok;
    assign accept   = br_valid & br_ready;

    always_comb begin
        nzcv_next       = nzcv_reg;
        res_valid_next  = res_valid_reg;
        res_taken_next  = res_taken_reg;
        res_target_next = res_target_reg;

        if (flag_we) begin
            nzcv_next = alu_flags;
        end

        if (flush) begin
            // accept is already blocked by br_ready; contents are left as-is.
            res_valid_next = 1'b0;
        end else if (accept) begin
            res_valid_next  = 1'b1;
            res_taken_next  = cond_vec[br_cond];
            res_target_next = br_target;
        end else if (res_ready) begin
            res_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzcv_reg       <= 4'b0000;
            res_valid_reg  <= 1'b0;
            res_taken_reg  <= 1'b0;
            res_target_reg <= '0;
        end else begin
            nzcv_reg       <= nzcv_next;
            res_valid_reg  <= res_valid_next;
            res_taken_reg  <= res_taken_next;
            res_target_reg <= res_target_next;
        end
    end

    assign nzcv       = nzcv_reg;
    assign res_valid  = res_valid_reg;
    assign res_taken  = res_taken_reg;
    assign res_target = res_target_reg;

endmodule

// File: tb/tb_flags_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_flags_branch_unit
//
// Directed bench for flags_branch_unit. Stimulus pushes the hand-computed
// {taken, target} of every accepted branch into a queue; a monitor pops and
// compares whenever the DUT presents a result that fetch consumes. Handshake,
// stall, flush and reset behaviour are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_flags_branch_unit;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         flags_valid, write_flags;
    logic         zero_flag, negative, carry, overflow;
    logic         br_valid;
    logic [3:0]   br_cond;
    logic [N-1:0] br_target;
    logic         br_ready;
    logic         res_valid, res_taken;
    logic [N-1:0] res_target;
    logic         res_ready;
    logic         flush;
    logic [3:0]   nzcv;

    typedef struct packed {
        logic         taken;
        logic [N-1:0] target;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    flags_branch_unit #(.N(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flags_valid (flags_valid),
        .write_flags (write_flags),
        .zero_flag   (zero_flag),
        .negative    (negative),
        .carry       (carry),
        .overflow    (overflow),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_target   (br_target),
        .br_ready    (br_ready),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_target  (res_target),
        .res_ready   (res_ready),
        .flush       (flush),
        .nzcv        (nzcv)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    // Monitor: compare each consumed result against the scoreboard.
    always @(negedge clk) begin
        if (reset_n && res_valid && res_ready) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got taken=%0b target=0x%0h expected no result at %0t",
                         res_taken, res_target, $time);
            end else begin
                e = exp_q.pop_front();
                if (res_taken !== e.taken || res_target !== e.target) begin
                    errors++;
                    $display("FAIL result: got taken=%0b target=0x%0h expected taken=%0b target=0x%0h at %0t",
                             res_taken, res_target, e.taken, e.target, $time);
                end else begin
                    $display("ok   result: taken=%0b target=0x%0h at %0t", res_taken, res_target, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_fl(input logic n, input logic z, input logic c, input logic v, input logic fv);
        flags_valid = fv;
        write_flags = 1'b1;
        negative    = n;
        zero_flag   = z;
        carry       = c;
        overflow    = v;
        tick();
        flags_valid = 1'b0;
        write_flags = 1'b0;
    endtask

    // Offer a branch until accepted (bounded), push its expected result.
    task automatic send_branch(input logic [3:0] cc, input logic [N-1:0] tgt, input logic exp_taken);
        bit done = 0;
        br_valid  = 1'b1;
        br_cond   = cc;
        br_target = tgt;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (br_ready) begin
                exp_q.push_back('{taken: exp_taken, target: tgt});
                done = 1;
            end
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cond=%0d not accepted within 20 cycles", cc);
        end
        br_valid = 1'b0;
    endtask

    initial begin
        exp_t dropped;
        reset_n     = 1'b0;
        flags_valid = 0; write_flags = 0;
        zero_flag   = 0; negative = 0; carry = 0; overflow = 0;
        br_valid    = 0; br_cond = 4'd0; br_target = '0;
        res_ready   = 1'b1;
        flush       = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_nzcv", 64'(nzcv), 64'h0);
        check("rst_res_valid", 64'(res_valid), 64'h0);
        check("rst_res_taken", 64'(res_taken), 64'h0);
        check("rst_res_target", res_target, 64'h0);
        reset_n = 1'b1;
        repeat (2) tick();
        check("idle_res_valid", 64'(res_valid), 64'h0);

        // AL branch, one-cycle latency
        send_branch(4'd14, 64'h400, 1'b1);
        check("lat1_res_valid", 64'(res_valid), 64'h1);
        check("lat1_res_target", res_target, 64'h400);
        tick();

        // Z=1 C=1 (equal-operand SUBS)
        write_fl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("nzcv_after_subs", 64'(nzcv), 64'h6);
        send_branch(4'd0,  64'h1000, 1'b1);
        send_branch(4'd1,  64'h1008, 1'b0);
        send_branch(4'd8,  64'h1010, 1'b0);
        send_branch(4'd9,  64'h1018, 1'b1);
        send_branch(4'd10, 64'h1020, 1'b1);

        // N=1 V=0
        write_fl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("nzcv_n_set", 64'(nzcv), 64'h8);
        send_branch(4'd11, 64'h1100, 1'b1);
        send_branch(4'd12, 64'h1108, 1'b0);
        send_branch(4'd13, 64'h1110, 1'b1);
        send_branch(4'd4,  64'h1118, 1'b1);
        send_branch(4'd7,  64'h1120, 1'b1);
        send_branch(4'd15, 64'h1128, 1'b1);

        // Write strobe during a bubble is ignored
        write_fl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("nzcv_bubble_hold", 64'(nzcv), 64'h8);

        // Backpressure: hold for 3 cycles, then back-to-back
        res_ready = 1'b0;
        send_branch(4'd5, 64'h1234, 1'b0);
        br_valid  = 1'b1;
        br_cond   = 4'd14;
        br_target = 64'h2000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_br_ready", 64'(br_ready), 64'h0);
            check("hold_res_valid", 64'(res_valid), 64'h1);
            check("hold_res_taken", 64'(res_taken), 64'h0);
            check("hold_res_target", res_target, 64'h1234);
        end
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        check("b2b_br_ready", 64'(br_ready), 64'h1);
        if (br_ready) exp_q.push_back('{taken: 1'b1, target: 64'h2000});
        tick();
        br_valid = 1'b0;
        check("b2b_res_valid", 64'(res_valid), 64'h1);
        check("b2b_res_target", res_target, 64'h2000);
        tick();

        // Same-cycle flag write (Z 0->1) and EQ branch
        flags_valid = 1'b1; write_flags = 1'b1;
        negative = 0; zero_flag = 1; carry = 0; overflow = 0;
        br_valid = 1'b1; br_cond = 4'd0; br_target = 64'h3000;
        @(negedge clk);
`ifdef FLAGS_BYPASS_EN
        check("byp_br_ready", 64'(br_ready), 64'h1);
        if (br_ready) exp_q.push_back('{taken: 1'b1, target: 64'h3000});
        tick();
        flags_valid = 0; write_flags = 0; br_valid = 0;
`else
        check("stall_br_ready", 64'(br_ready), 64'h0);
        tick();
        flags_valid = 0; write_flags = 0;
        @(negedge clk);
        check("stall_next_br_ready", 64'(br_ready), 64'h1);
        if (br_ready) exp_q.push_back('{taken: 1'b1, target: 64'h3000});
        tick();
        br_valid = 0;
`endif
        check("samecyc_res_valid", 64'(res_valid), 64'h1);
        check("samecyc_res_taken", 64'(res_taken), 64'h1);
        check("samecyc_nzcv", 64'(nzcv), 64'h4);
        tick();

        // Flush while holding a result with a request pending
        res_ready = 1'b0;
        send_branch(4'd0, 64'h5000, 1'b1);
        flush = 1'b1; br_valid = 1'b1; br_cond = 4'd1; br_target = 64'h6000;
        @(negedge clk);
        check("flush_br_ready", 64'(br_ready), 64'h0);
        tick();
        flush = 1'b0; br_valid = 1'b0;
        check("flush_res_valid", 64'(res_valid), 64'h0);
        check("flush_nzcv", 64'(nzcv), 64'h4);
        if (exp_q.size() > 0) dropped = exp_q.pop_front();
        res_ready = 1'b1;
        tick();
        check("flush_stays_empty", 64'(res_valid), 64'h0);

        // Async reset mid-hold
        res_ready = 1'b0;
        send_branch(4'd14, 64'h7000, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_res_valid", 64'(res_valid), 64'h0);
        check("arst_nzcv", 64'(nzcv), 64'h0);
        check("arst_res_target", res_target, 64'h0);
        if (exp_q.size() > 0) dropped = exp_q.pop_front();
        res_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();

        // C=1 V=1 after reset
        write_fl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("nzcv_cv", 64'(nzcv), 64'h3);
        send_branch(4'd2,  64'h8000, 1'b1);
        send_branch(4'd3,  64'h8008, 1'b0);
        send_branch(4'd6,  64'h8010, 1'b1);
        send_branch(4'd10, 64'h8018, 1'b0);
        repeat (3) tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
